bfly_inject_port: RTL

- Per-port injection stage directly upstream of the sym_butterfly input channels. One instance per butterfly port.
- Buffers flits from a terminal in a small FIFO, frames wormhole packets, and latches the destination route address from each head flit.
- Presents flits to the first-layer 4-radix switch node with valid/ready backpressure.

---
 rtl/bfly_inject_port.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bfly_inject_port.sv
// Injection stage for one sym_butterfly port: it buffers terminal flits, frames wormhole packets and latches each packet's route.
// Define BFLY_FRAME_CHECK_EN to drop stray body flits and flag framing errors on the sticky err output.
module bfly_inject_port #(
    parameter int PORTS         = 64,
    parameter int CHANNEL_WIDTH = 18,
    parameter int FIFO_DEPTH    = 8,
    localparam int ADR_W        = $clog2(PORTS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNEL_WIDTH-1:0] in_flit,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [CHANNEL_WIDTH-1:0] out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADR_W-1:0]         r_adr,
    output logic                     busy,
    output logic                     err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, SEND} state_t;

    logic [CHANNEL_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         count_q;
    state_t                   state_q, state_d;
    logic [ADR_W-1:0]         r_adr_q, r_adr_d;
    logic [CHANNEL_WIDTH-1:0] head_flit;
    logic                     full, empty, push, pop, drop, tail_bit;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign pop       = (out_valid && out_ready) || drop;
    assign head_flit = mem_q[rd_ptr_q];
    assign tail_bit  = head_flit[CHANNEL_WIDTH-2];
    assign out_ch    = head_flit;
    assign r_adr     = r_adr_q;
    assign busy      = (state_q == SEND);

    // Storage is left unreset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_flit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (!push && pop) count_q <= count_q - CNT_W'(1);
        end
    end

`ifdef BFLY_FRAME_CHECK_EN
    logic head_bit;
    logic err_q, err_d;
    // first_q marks the packet's own head flit, which legitimately carries head=1 in SEND.
    logic first_q, first_d;

    assign head_bit = head_flit[CHANNEL_WIDTH-1];
    assign err      = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            err_q   <= err_d;
            first_q <= first_d;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_adr_q <= '0;
        end else begin
            state_q <= state_d;
            r_adr_q <= r_adr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        r_adr_d   = r_adr_q;
        out_valid = 1'b0;
        drop      = 1'b0;
`ifdef BFLY_FRAME_CHECK_EN
        err_d     = err_q;
        first_d   = first_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
`ifdef BFLY_FRAME_CHECK_EN
                    if (!head_bit) begin
                        drop  = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        r_adr_d = head_flit[ADR_W-1:0];
                        state_d = SEND;
                        first_d = 1'b1;
                    end
`else
                    r_adr_d = head_flit[ADR_W-1:0];
                    state_d = SEND;
`endif
                end
            end
            SEND: begin
                out_valid = !empty;
                if (out_valid && out_ready) begin
`ifdef BFLY_FRAME_CHECK_EN
                    first_d = 1'b0;
                    if (head_bit && !first_q) err_d = 1'b1;
`endif
                    if (tail_bit) state_d = IDLE;
                end
            end
        endcase
    end

endmodule
